// File: rtl/mod_writeback_buffer_pkg.sv
// Shared types and defaults for the writeback buffer and its forwarding matcher.
// Entry layout is {destination register, result data}.
package mod_writeback_buffer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mod_writeback_buffer_fwd_match.sv
// Youngest-first lookup of one register address across the occupied entries
// of the circular writeback buffer.
module mod_wb_fwd_match
  import mod_writeback_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] i_entry_addr [DEPTH],
  input  logic [DATA_W-1:0] i_entry_data [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic [PTR_W-1:0] w_idx;

  // NOTE: every output of this always_comb gets a default first so no path
  // through the loop can leave a value held, which would infer a latch.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = i_head;
    // Walk oldest to youngest; a later match overwrites, so the youngest wins.
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if ((CNT_W'(k) < i_count) &&
          (i_lookup_addr != ADDR_W'(ZERO_REG)) &&
          (i_entry_addr[w_idx] == i_lookup_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entry_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/mod_writeback_buffer.sv
// Age-ordered buffer of pending register-file writes from the load and ALU
// paths, drained one per cycle, with two forwarding lookup ports for decode.
module mod_writeback_buffer
  import mod_writeback_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_address,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              hold,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] fwd_address_1,
  input  logic [ADDR_W-1:0] fwd_address_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_free;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_slot;

  // Space comes from the registered count only, so a pop this cycle never
  // lets a push in; the full-buffer ready drop lasts one extra cycle.
  assign w_free    = CNT_W'(DEPTH) - r_count;
  assign mem_ready = (w_free != '0);
  assign alu_ready = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !mem_valid);

  assign w_mem_push = mem_valid && mem_ready && (mem_address != ADDR_W'(ZERO_REG));
  assign w_alu_push = alu_valid && alu_ready && (alu_address != ADDR_W'(ZERO_REG));
  assign w_alu_slot = r_tail + PTR_W'(w_mem_push);

  assign rf_write         = (r_count != '0);
  assign rf_write_address = r_addr[r_head];
  assign rf_write_data    = r_data[r_head];
  assign w_pop            = rf_write && !hold;
  assign count            = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
      r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read under
  // the count mask, so clearing the pointers is enough to discard them.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_addr[r_tail] <= mem_address;
      r_data[r_tail] <= mem_data;
    end
    if (w_alu_push) begin
      r_addr[w_alu_slot] <= alu_address;
      r_data[w_alu_slot] <= alu_data;
    end
  end

  mod_wb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_1 (
    .i_entry_addr  (r_addr),
    .i_entry_data  (r_data),
    .i_head        (r_head),
    .i_count       (r_count),
    .i_lookup_addr (fwd_address_1),
    .o_hit         (fwd_hit_1),
    .o_data        (fwd_data_1)
  );

  mod_wb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_2 (
    .i_entry_addr  (r_addr),
    .i_entry_data  (r_data),
    .i_head        (r_head),
    .i_count       (r_count),
    .i_lookup_addr (fwd_address_2),
    .o_hit         (fwd_hit_2),
    .o_data        (fwd_data_2)
  );

endmodule

// File: tb/tb_mod_writeback_buffer.sv
// Self-checking bench for mod_writeback_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_mod_writeback_buffer;
  import mod_writeback_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = DEF_DATA_W;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_valid, alu_valid, hold;
  logic [ADDR_W-1:0] mem_address, alu_address, fwd_address_1, fwd_address_2;
  logic [DATA_W-1:0] mem_data, alu_data;
  logic              mem_ready, alu_ready, rf_write, fwd_hit_1, fwd_hit_2;
  logic [ADDR_W-1:0] rf_write_address;
  logic [DATA_W-1:0] rf_write_data, fwd_data_1, fwd_data_2;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  wb_entry_t model_q[$];
  logic      exp_mem_ready, exp_alu_ready;
  logic      mem_acc = 1'b0;
  logic      alu_acc = 1'b0;

  always #5 clk = ~clk;

  mod_writeback_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_valid        (mem_valid),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_ready        (mem_ready),
    .alu_valid        (alu_valid),
    .alu_address      (alu_address),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .hold             (hold),
    .rf_write         (rf_write),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .fwd_address_1    (fwd_address_1),
    .fwd_address_2    (fwd_address_2),
    .fwd_hit_1        (fwd_hit_1),
    .fwd_hit_2        (fwd_hit_2),
    .fwd_data_1       (fwd_data_1),
    .fwd_data_2       (fwd_data_2),
    .count            (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to a nonzero register, searched newest first.
  function automatic void model_fwd(input logic [ADDR_W-1:0] a,
                                    output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].address == a) begin
          hit = 1'b1;
          d   = model_q[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic check_model();
    int                free;
    logic              h;
    logic [DATA_W-1:0] d;
    free          = DEPTH - model_q.size();
    exp_mem_ready = (free >= 1);
    exp_alu_ready = (free >= 2) || (free == 1 && !mem_valid);
    check("count", count, model_q.size());
    check("rf_write", rf_write, model_q.size() != 0);
    if (model_q.size() != 0) begin
      check("rf_write_address", rf_write_address, model_q[0].address);
      check("rf_write_data", rf_write_data, model_q[0].data);
    end
    check("mem_ready", mem_ready, exp_mem_ready);
    check("alu_ready", alu_ready, exp_alu_ready);
    model_fwd(fwd_address_1, h, d);
    check("fwd_hit_1", fwd_hit_1, h);
    check("fwd_data_1", fwd_data_1, d);
    model_fwd(fwd_address_2, h, d);
    check("fwd_hit_2", fwd_hit_2, h);
    check("fwd_data_2", fwd_data_2, d);
  endtask

  // One clock: check at the falling edge, then apply the edge to the model.
  task automatic tick();
    logic pop;
    @(negedge clk);
    check_model();
    mem_acc = mem_valid && exp_mem_ready;
    alu_acc = alu_valid && exp_alu_ready;
    pop     = (model_q.size() != 0) && !hold;
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (mem_acc && mem_address != '0) model_q.push_back('{address: mem_address, data: mem_data});
    if (alu_acc && alu_address != '0) model_q.push_back('{address: alu_address, data: alu_data});
    #1;
  endtask

  initial begin
    mem_valid = 1'b0; mem_address = '0; mem_data = '0;
    alu_valid = 1'b0; alu_address = '0; alu_data = '0;
    hold = 1'b0; fwd_address_1 = '0; fwd_address_2 = '0;

    #12;
    check("rst_count", count, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_fwd_hit_1", fwd_hit_1, 0);
    check("rst_fwd_data_1", fwd_data_1, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single ALU write r5 = 0x1234.
    alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'h1234; fwd_address_1 = 5'd5;
    tick();
    alu_valid = 1'b0;
    check("t1_rf_write", rf_write, 1);
    check("t1_rf_addr", rf_write_address, 5);
    check("t1_rf_data", rf_write_data, 32'h1234);
    check("t1_fwd_hit", fwd_hit_1, 1);
    check("t1_fwd_data", fwd_data_1, 32'h1234);
    tick();
    check("t1_count_after", count, 0);
    check("t1_fwd_gone", fwd_hit_1, 0);

    // Same-cycle mem and ALU writes to r3 under hold.
    hold = 1'b1; fwd_address_1 = 5'd3;
    mem_valid = 1'b1; mem_address = 5'd3; mem_data = 32'hAAAA;
    alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'hBBBB;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check("t2_count", count, 2);
    check("t2_fwd_young", fwd_data_1, 32'hBBBB);
    check("t2_head_data", rf_write_data, 32'hAAAA);
    hold = 1'b0;
    tick();
    check("t2_second_addr", rf_write_address, 3);
    check("t2_second_data", rf_write_data, 32'hBBBB);
    tick();
    check("t2_drained", count, 0);

    // Fill to DEPTH, single pop, then the one-free-slot rule.
    hold = 1'b1;
    mem_valid = 1'b1; mem_address = 5'd1; mem_data = 32'h11;
    alu_valid = 1'b1; alu_address = 5'd2; alu_data = 32'h22;
    tick();
    mem_address = 5'd4; mem_data = 32'h44;
    alu_address = 5'd6; alu_data = 32'h66;
    tick();
    mem_address = 5'd9; mem_data = 32'h99;
    alu_address = 5'd10; alu_data = 32'h100;
    check("t3_full_count", count, 4);
    check("t3_full_mem_ready", mem_ready, 0);
    check("t3_full_alu_ready", alu_ready, 0);
    hold = 1'b0;
    #1;
    check("t3_pop_mem_ready", mem_ready, 0);
    tick();
    hold = 1'b1;
    check("t3_after_pop_count", count, 3);
    check("t3_after_pop_mem_ready", mem_ready, 1);
    check("t3_alu_refused", alu_ready, 0);
    tick();
    check("t3_refill_count", count, 4);
    mem_valid = 1'b0; alu_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t3_drained", count, 0);

    // Writes to r0 handshake but never enqueue or hit.
    mem_valid = 1'b1; mem_address = 5'd0; mem_data = 32'h5;
    alu_valid = 1'b1; alu_address = 5'd0; alu_data = 32'h6;
    fwd_address_1 = 5'd0; fwd_address_2 = 5'd0;
    tick();
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check("t4_count", count, 0);
    check("t4_rf_write", rf_write, 0);
    check("t4_fwd_hit", fwd_hit_1, 0);

    // Reset asserted mid-drain with three entries.
    hold = 1'b1; fwd_address_1 = 5'd7; fwd_address_2 = 5'd9;
    mem_valid = 1'b1; mem_address = 5'd7; mem_data = 32'h77;
    alu_valid = 1'b1; alu_address = 5'd8; alu_data = 32'h88;
    tick();
    mem_valid = 1'b0; alu_address = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    check("t5_pre_count", count, 3);
    hold = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    check("t5_count", count, 0);
    check("t5_rf_write", rf_write, 0);
    check("t5_fwd_hit_1", fwd_hit_1, 0);
    check("t5_fwd_hit_2", fwd_hit_2, 0);
    check("t5_fwd_data_2", fwd_data_2, 0);
    check("t5_mem_ready", mem_ready, 1);
    check("t5_alu_ready", alu_ready, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Random traffic; an offer left unaccepted stays stable until taken.
    mem_acc = 1'b0; alu_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(mem_valid && !mem_acc)) begin
        mem_valid   = 1'($urandom_range(0, 1));
        mem_address = ADDR_W'($urandom_range(0, 7));
        mem_data    = $urandom;
      end
      if (!(alu_valid && !alu_acc)) begin
        alu_valid   = 1'($urandom_range(0, 1));
        alu_address = ADDR_W'($urandom_range(0, 7));
        alu_data    = $urandom;
      end
      hold          = ($urandom_range(0, 3) == 0);
      fwd_address_1 = ADDR_W'($urandom_range(0, 7));
      fwd_address_2 = ADDR_W'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_writeback_buffer.md
# mod_writeback_buffer

Buffers results from the ALU and load paths and drains them, one per cycle, into the register-file write port (write address, write data, write, hold). Holds up to DEPTH pending writes in age order and provides forwarding lookups so decode reads return values not yet committed. Sits between execute/memory completion and `mod_register_file`.

## Interface
- DEPTH, 4: pending-entry capacity; power of two, ≥ 2.
- DATA_W, 32: data width.
- ADDR_W, 5: register address width.

- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- mem_valid  in  1  load result offered.
- mem_address  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- mem_ready  out  1  load result accepted when mem_valid & mem_ready at a rising edge.
- alu_valid  in  1  ALU result offered.
- alu_address  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU handshake, same rule.
- hold  in  1  register-file stall; no drain while high.
- rf_write  out  1  head entry presented to the register file.
- rf_write_address  out  ADDR_W  head destination.
- rf_write_data  out  DATA_W  head data.
- fwd_address_1, fwd_address_2  in  ADDR_W  decode read addresses.
- fwd_hit_1, fwd_hit_2  out  1  a pending entry matches.
- fwd_data_1, fwd_data_2  out  DATA_W  youngest matching data; 0 when no hit.
- count  out  log2(DEPTH)+1  occupied entries.

## Operation
- Circular buffer: head pointer, tail pointer, count. Pointers wrap modulo DEPTH.
- free = DEPTH − count, from the registered count only. A same-cycle pop does not create space.
- mem_ready = (free ≥ 1). alu_ready = (free ≥ 2) | (free == 1 & !mem_valid).
- Both accepted in one cycle: the mem entry is enqueued first (older), the ALU entry second.
- Writes to register 0 complete the handshake but are not enqueued and do not change count.
- Drain: rf_write = (count ≠ 0). rf_write_address and rf_write_data come from the head entry. On a rising edge with rf_write & !hold, the head is popped.
- count_next = count + pushes − pop. Push and pop in the same cycle are legal.
- Forwarding: compare each fwd_address against all occupied entries; the youngest match wins.
  - Address 0 never hits.
  - The entry being popped this cycle still hits, because the register file commits at the same edge.
  - Combinational from registered state only.
- Reset (async, low): pointers and count = 0, rf_write = 0, fwd_hit = 0, fwd_data = 0. mem_ready and alu_ready go high. Pending entries are discarded, including mid-drain.

## Timing
- Accept at edge T: the entry is visible to forwarding and, if it is the head, rf_write = 1 during cycle T+1. It commits at edge T+1 if hold is low.
- Enqueue throughput up to 2/cycle; drain 1/cycle. hold high freezes drain indefinitely; rf_write stays asserted with a stable head.
- Full (count = DEPTH): both ready outputs low, even if a pop occurs that cycle. They rise the cycle after the pop.
- Inputs must be stable while valid & !ready. Valid may drop without acceptance.
- Reset deassertion is synchronised externally. The first handshake is legal on the first rising edge after release.

## Structure
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - ZERO_REG = 5'd0.
  - wb_entry_t = {address[ADDR_W], data[DATA_W]}.
- One sub-module, `mod_wb_fwd_match`: a youngest-first match over DEPTH entries given head and count. It is instantiated twice, once per forwarding port.
- The storage array and pointer logic stay in the top module.

## Test plan
- Single ALU write r5=0x1234 with hold=0:
  - cycle+1: rf_write=1, address 5, data 0x1234.
  - count returns to 0 one cycle later.
  - fwd_address_1=5 hits with 0x1234 during cycle+1 only.
- Simultaneous mem r3=0xAAAA and alu r3=0xBBBB, hold=1:
  - count=2; fwd on r3 returns 0xBBBB.
  - Release hold: rf_write shows r3=0xAAAA, then r3=0xBBBB.
- Fill to DEPTH=4 with hold=1:
  - mem_ready=alu_ready=0.
  - Drop hold for one cycle: one pop, count=3, ready rises the next cycle.
  - With free=1, ALU is refused while mem_valid=1.
- Writes to r0 from both ports: handshakes complete, count stays 0, rf_write stays 0, fwd on r0 never hits.
- Assert reset low mid-drain with 3 entries: immediately count=0, rf_write=0, fwd_hit=0, ready=1. No further writes appear after release.
